// File: rtl/vga_capture.sv
// vga_capture: passive VGA timing recovery and frame checker.
// Recovers pixel coordinates and display-enable from hsync/vsync. Measures
// line and frame periods, locks after consistent frames, and keeps a 16-bit
// additive checksum of the active pixels of each frame.
// Ports:
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   hsync, vsync, rgb  VGA pins (syncs active low, rgb = {R,G,B} 2b each)
//   pix_x, pix_y, de   recovered coordinates (0 when de=0) and enable
//   h_total, v_total   last measured line period (clocks) / frame length (lines)
//   locked             timing locked
//   frame_sum          checksum of the last complete frame
//   frame_done         one-cycle pulse when frame_sum/v_total update
module vga_capture #(
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        de,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        locked,
  output logic [15:0] frame_sum,
  output logic        frame_done
);

  localparam logic [9:0] HS = 10'(H_START);
  localparam logic [9:0] HE = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] VS = 10'(V_START);
  localparam logic [9:0] VE = 10'(V_START + V_ACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs1_q, hs2_q, hs3_q, vs1_q, vs2_q, vs3_q;
  logic [5:0]  rgb1_q, rgb2_q;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0]  h_total_q, h_total_d, v_total_q, v_total_d, v_ref_q, v_ref_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [7:0]  good_q, good_d;
  logic        line_bad_q, line_bad_d, have_prev_q, have_prev_d;
  logic [15:0] sum_q, sum_d, frame_sum_q, frame_sum_d;
  logic        de_q, de_d, frame_done_q, frame_done_d, locked_q, locked_d;
  logic        hfall, vfall, lost, frame_ok;
  logic [9:0]  h_period, vcnt_inc, v_meas;

  assign hfall = hs3_q & ~hs2_q;
  assign vfall = vs3_q & ~vs2_q;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = (hcnt_q == '1) ? hcnt_q : hcnt_q + 10'd1;
    vcnt_d       = vcnt_q;
    h_total_d    = h_total_q;
    v_total_d    = v_total_q;
    v_ref_d      = v_ref_q;
    good_d       = good_q;
    line_bad_d   = line_bad_q;
    have_prev_d  = have_prev_q;
    sum_d        = sum_q;
    frame_sum_d  = frame_sum_q;
    frame_done_d = 1'b0;
    frame_ok     = 1'b0;
    h_period     = hcnt_q + 10'd1;
    vcnt_inc     = (vcnt_q == '1) ? vcnt_q : vcnt_q + 10'd1;
    // A vsync fall normally coincides with an hsync fall; the line ending
    // there is counted so the frame length comes out in whole lines.
    v_meas       = hfall ? vcnt_inc : vcnt_q;
    lost         = ((hcnt_q == '1) && !hfall) || ((vcnt_q == '1) && !vfall);

    if (hfall) begin
      hcnt_d      = '0;
      vcnt_d      = vcnt_inc;
      h_total_d   = h_period;
      // The first line of a frame has no in-frame predecessor to compare to.
      if (have_prev_q && (h_period != h_total_q)) line_bad_d = 1'b1;
      have_prev_d = 1'b1;
    end
    if (vfall) vcnt_d = '0;

    de_d    = (hcnt_q >= HS) && (hcnt_q < HE) && (vcnt_q >= VS) && (vcnt_q < VE) &&
              (state_q != SEARCH);
    pix_x_d = de_d ? hcnt_q - HS : '0;
    pix_y_d = de_d ? vcnt_q - VS : '0;
    if (de_d) sum_d = sum_q + {10'd0, rgb2_q};

    if (lost) begin
      state_d     = SEARCH;
      good_d      = '0;
      line_bad_d  = 1'b0;
      have_prev_d = 1'b0;
      sum_d       = '0;
    end else if (vfall) begin
      line_bad_d  = 1'b0;
      have_prev_d = 1'b0;
      sum_d       = '0;
      frame_ok    = !line_bad_q && ((good_q == '0) || (v_meas == v_ref_q));
      case (state_q)
        SEARCH: begin
          state_d = TRACK;
          good_d  = '0;
        end
        TRACK: begin
          v_ref_d = v_meas;
          if (frame_ok) good_d = good_q + 8'd1;
          else          good_d = line_bad_q ? 8'd0 : 8'd1;
          if (good_d >= LOCK_N) state_d = LOCKED;
        end
        LOCKED: begin
          v_ref_d = v_meas;
          if (!frame_ok) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
      if (state_q != SEARCH) begin
        frame_sum_d  = sum_q;
        v_total_d    = v_meas;
        frame_done_d = 1'b1;
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Sync stages idle high so reset release never looks like a fall.
      {hs1_q, hs2_q, hs3_q, vs1_q, vs2_q, vs3_q} <= '1;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      state_q      <= SEARCH;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      h_total_q    <= '0;
      v_total_q    <= '0;
      v_ref_q      <= '0;
      good_q       <= '0;
      line_bad_q   <= 1'b0;
      have_prev_q  <= 1'b0;
      sum_q        <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
      de_q         <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      locked_q     <= 1'b0;
    end else begin
      hs1_q        <= hsync;
      hs2_q        <= hs1_q;
      hs3_q        <= hs2_q;
      vs1_q        <= vsync;
      vs2_q        <= vs1_q;
      vs3_q        <= vs2_q;
      rgb1_q       <= rgb;
      rgb2_q       <= rgb1_q;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      h_total_q    <= h_total_d;
      v_total_q    <= v_total_d;
      v_ref_q      <= v_ref_d;
      good_q       <= good_d;
      line_bad_q   <= line_bad_d;
      have_prev_q  <= have_prev_d;
      sum_q        <= sum_d;
      frame_sum_q  <= frame_sum_d;
      frame_done_q <= frame_done_d;
      de_q         <= de_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      locked_q     <= locked_d;
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign de         = de_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign locked     = locked_q;
  assign frame_sum  = frame_sum_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using a reduced timing: 50-clock lines, 34-line
// frames, 40x30 active area starting at hcnt 6 / vcnt 2.
module tb_vga_capture;

  logic        clk = 1'b0;
  logic        rst_n, hsync, vsync;
  logic [5:0]  rgb;
  logic [9:0]  pix_x, pix_y, h_total, v_total;
  logic        de, locked, frame_done;
  logic [15:0] frame_sum;

  vga_capture #(.H_START(6), .H_ACTIVE(40), .V_START(2), .V_ACTIVE(30), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .h_total(h_total), .v_total(v_total),
    .locked(locked), .frame_sum(frame_sum), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, fd_cnt = 0, fd_cyc = -1, nz_cnt = 0;
  int lk_rise_cyc = -1, lk_fall_cyc = -1, ht51_cyc = -1, sp_cyc = -1;
  int fr_de = 0, fr_xmin = 1023, fr_xmax = 0, fr_ymin = 1023, fr_ymax = 0;
  int last_de = -1, last_xmin = -1, last_xmax = -1, last_ymin = -1, last_ymax = -1;
  int vf_mark = 0, hf11_mark = 0, sp_mark = 0, lastline_mark = 0;
  logic       lk_prev = 1'b0;
  logic [9:0] ht_prev = '0;

  // Observation process: samples 1 time unit after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (de) begin
        fr_de = fr_de + 1;
        if (int'(pix_x) < fr_xmin) fr_xmin = int'(pix_x);
        if (int'(pix_x) > fr_xmax) fr_xmax = int'(pix_x);
        if (int'(pix_y) < fr_ymin) fr_ymin = int'(pix_y);
        if (int'(pix_y) > fr_ymax) fr_ymax = int'(pix_y);
        if (pix_x == 10'd5 && pix_y == 10'd7) sp_cyc = cyc;
      end else if (pix_x != '0 || pix_y != '0) begin
        nz_cnt = nz_cnt + 1;
      end
      if (locked && !lk_prev) lk_rise_cyc = cyc;
      if (!locked && lk_prev) lk_fall_cyc = cyc;
      lk_prev = locked;
      if (h_total != ht_prev && h_total == 10'd51) ht51_cyc = cyc;
      ht_prev = h_total;
      if (frame_done) begin
        fd_cnt = fd_cnt + 1;
        fd_cyc = cyc;
        last_de = fr_de; last_xmin = fr_xmin; last_xmax = fr_xmax;
        last_ymin = fr_ymin; last_ymax = fr_ymax;
        fr_de = 0; fr_xmin = 1023; fr_xmax = 0; fr_ymin = 1023; fr_ymax = 0;
      end
    end
  end

  // One frame (or its first n_lines lines) starting with a coincident
  // hsync/vsync fall; rgb is 'solid' except one optional single sample.
  task automatic drive_frame(input int n_lines, input logic [5:0] solid, input int long_line,
                             input int sp_line, input int sp_samp, input logic [5:0] sp_val);
    int len;
    for (int ln = 0; ln < n_lines; ln++) begin
      len = (ln == long_line) ? 51 : 50;
      for (int s = 0; s < len; s++) begin
        @(negedge clk);
        hsync = (s < 3) ? 1'b0 : 1'b1;
        vsync = (ln < 2) ? 1'b0 : 1'b1;
        rgb   = (ln == sp_line && s == sp_samp) ? sp_val : solid;
        if (ln == 0 && s == 0) vf_mark = cyc;
        if (ln == 11 && s == 0) hf11_mark = cyc;
        if (ln == n_lines - 1 && s == 0) lastline_mark = cyc;
        if (ln == sp_line && s == sp_samp) sp_mark = cyc;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (pix_x !== 10'd0) begin errors++; $display("FAIL reset_pix_x: got %0d expected 0", pix_x); end
    checks++; if (pix_y !== 10'd0) begin errors++; $display("FAIL reset_pix_y: got %0d expected 0", pix_y); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", de); end
    checks++; if (h_total !== 10'd0) begin errors++; $display("FAIL reset_h_total: got %0d expected 0", h_total); end
    checks++; if (v_total !== 10'd0) begin errors++; $display("FAIL reset_v_total: got %0d expected 0", v_total); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (frame_sum !== 16'h0000) begin errors++; $display("FAIL reset_frame_sum: got %h expected 0000", frame_sum); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
  endtask

  task automatic test_lock();
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (fd_cnt !== 0) begin errors++; $display("FAIL lock_no_done_search: got %0d expected 0", fd_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_f1_locked: got %b expected 0", locked); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL lock_f2_done_cnt: got %0d expected 1", fd_cnt); end
    checks++; if (fd_cyc !== vf_mark + 3) begin errors++; $display("FAIL lock_f2_done_time: got %0d expected %0d", fd_cyc, vf_mark + 3); end
    checks++; if (h_total !== 10'd50) begin errors++; $display("FAIL lock_h_total: got %0d expected 50", h_total); end
    checks++; if (v_total !== 10'd34) begin errors++; $display("FAIL lock_v_total: got %0d expected 34", v_total); end
    checks++; if (frame_sum !== 16'h0000) begin errors++; $display("FAIL lock_frame_sum: got %h expected 0000", frame_sum); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_f2_locked: got %b expected 0", locked); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (lk_rise_cyc !== vf_mark + 3) begin errors++; $display("FAIL lock_rise_time: got %0d expected %0d", lk_rise_cyc, vf_mark + 3); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_f3_locked: got %b expected 1", locked); end
  endtask

  task automatic test_solid();
    drive_frame(34, 6'h3F, -1, -1, -1, 6'h00);
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    // 1200 pixels * 63 = 75600 -> mod 65536 = 10064
    checks++; if (frame_sum !== 16'h2750) begin errors++; $display("FAIL solid_sum: got %h expected 2750", frame_sum); end
    checks++; if (last_de !== 1200) begin errors++; $display("FAIL solid_de_count: got %0d expected 1200", last_de); end
    checks++; if (last_xmin !== 0 || last_xmax !== 39) begin errors++; $display("FAIL solid_x_span: got %0d..%0d expected 0..39", last_xmin, last_xmax); end
    checks++; if (last_ymin !== 0 || last_ymax !== 29) begin errors++; $display("FAIL solid_y_span: got %0d..%0d expected 0..29", last_ymin, last_ymax); end
    checks++; if (nz_cnt !== 0) begin errors++; $display("FAIL solid_pix_zero_when_blank: got %0d expected 0", nz_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL solid_locked: got %b expected 1", locked); end
  endtask

  task automatic test_long_line();
    drive_frame(34, 6'h00, 10, -1, -1, 6'h00);
    checks++; if (ht51_cyc !== hf11_mark + 3) begin errors++; $display("FAIL long_h_total_time: got %0d expected %0d", ht51_cyc, hf11_mark + 3); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (lk_fall_cyc !== vf_mark + 3) begin errors++; $display("FAIL long_unlock_time: got %0d expected %0d", lk_fall_cyc, vf_mark + 3); end
    checks++; if (v_total !== 10'd34) begin errors++; $display("FAIL long_v_total: got %0d expected 34", v_total); end
    checks++; if (h_total !== 10'd50) begin errors++; $display("FAIL long_h_total_back: got %0d expected 50", h_total); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL long_relock_early: got %b expected 0", locked); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (lk_rise_cyc !== vf_mark + 3) begin errors++; $display("FAIL long_relock_time: got %0d expected %0d", lk_rise_cyc, vf_mark + 3); end
  endtask

  task automatic test_sync_loss();
    int fd0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      hsync = 1'b1; vsync = 1'b1; rgb = 6'h3F;
    end
    // hcnt is 0 three clocks after the last hsync pin fall, reaches 1023
    // 1023 clocks later, and the state leaves LOCKED on the following edge.
    checks++; if (lk_fall_cyc !== lastline_mark + 1027) begin errors++; $display("FAIL loss_unlock_time: got %0d expected %0d", lk_fall_cyc, lastline_mark + 1027); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %b expected 0", locked); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL loss_de: got %b expected 0", de); end
    fd0 = fd_cnt;
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL loss_no_done_search: got %0d expected %0d", fd_cnt, fd0); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL loss_done_pulse: got %0d expected %0d", fd_cnt, fd0 + 1); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_relock_early: got %b expected 0", locked); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (lk_rise_cyc !== vf_mark + 3) begin errors++; $display("FAIL loss_relock_time: got %0d expected %0d", lk_rise_cyc, vf_mark + 3); end
  endtask

  task automatic test_single_pixel();
    // x=5,y=7 -> line 2+7, sample 6+5+1 (hcnt lags the pin sample by one)
    drive_frame(34, 6'h00, -1, 9, 12, 6'h01);
    checks++; if (sp_cyc !== sp_mark + 3) begin errors++; $display("FAIL pixel_latency: got %0d expected %0d", sp_cyc, sp_mark + 3); end
    drive_frame(34, 6'h02, -1, -1, -1, 6'h00);
    checks++; if (frame_sum !== 16'h0001) begin errors++; $display("FAIL pixel_sum: got %h expected 0001", frame_sum); end
    checks++; if (last_de !== 1200) begin errors++; $display("FAIL pixel_de_count: got %0d expected 1200", last_de); end
  endtask

  task automatic test_reset_mid();
    int fd0;
    drive_frame(10, 6'h3F, -1, -1, -1, 6'h00);
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      hsync = (s < 3) ? 1'b0 : 1'b1; vsync = 1'b1; rgb = 6'h3F;
    end
    @(negedge clk);
    // 1200 * 2 = 2400 from the previous frame
    checks++; if (frame_sum !== 16'h0960) begin errors++; $display("FAIL mid_sum_before: got %h expected 0960", frame_sum); end
    checks++; if (de !== 1'b1 || pix_x !== 10'd10 || pix_y !== 10'd8) begin errors++; $display("FAIL mid_pix_before: got de=%b x=%0d y=%0d expected de=1 x=10 y=8", de, pix_x, pix_y); end
    rst_n = 1'b0;
    #1;
    checks++; if (de !== 1'b0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin errors++; $display("FAIL mid_reset_pix: got de=%b x=%0d y=%0d expected all 0", de, pix_x, pix_y); end
    checks++; if (h_total !== 10'd0 || v_total !== 10'd0) begin errors++; $display("FAIL mid_reset_totals: got %0d/%0d expected 0/0", h_total, v_total); end
    checks++; if (locked !== 1'b0 || frame_sum !== 16'h0000 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_reset_status: got locked=%b sum=%h done=%b expected 0/0000/0", locked, frame_sum, frame_done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fd0 = fd_cnt;
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (fd_cnt !== fd0) begin errors++; $display("FAIL mid_no_done_after_reset: got %0d expected %0d", fd_cnt, fd0); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %b expected 0", locked); end
    checks++; if (v_total !== 10'd34) begin errors++; $display("FAIL mid_v_total: got %0d expected 34", v_total); end
    drive_frame(34, 6'h00, -1, -1, -1, 6'h00);
    checks++; if (lk_rise_cyc !== vf_mark + 3) begin errors++; $display("FAIL mid_relock_time: got %0d expected %0d", lk_rise_cyc, vf_mark + 3); end
  endtask

  initial begin
    rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 6'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_lock();
    test_solid();
    test_long_line();
    test_sync_loss();
    test_single_pixel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Passive VGA timing recovery and frame-check block for the TinyVGA pin set: hsync, vsync and 2-bit R/G/B. It sits on the receive side of a loopback or external VGA source, in the same clock domain as the pixel clock. It does four things:
- recovers pixel coordinates and a display-enable;
- measures line and frame periods;
- declares lock after consistent frames;
- produces a 16-bit additive checksum per frame so a bench or host can verify the transmitted pattern.

## Interface
Parameters:
- H_START, 144: clocks from hsync falling edge to first active pixel
- H_ACTIVE, 640: active pixels per line
- V_START, 35: hsync falling edges after vsync falling edge before first active line
- V_ACTIVE, 480: active lines per frame
- LOCK_FRAMES, 2: consecutive consistent frames required for lock

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- rgb  in  6  {R[1:0],G[1:0],B[1:0]}
- pix_x  out  10  recovered x, 0 when de=0
- pix_y  out  10  recovered y, 0 when de=0
- de  out  1  recovered display-enable
- h_total  out  10  last measured line period in clocks
- v_total  out  10  last measured frame length in lines
- locked  out  1  timing locked
- frame_sum  out  16  checksum of last complete frame
- frame_done  out  1  one-cycle pulse when frame_sum/v_total update

## Operation
**Input stage**
- hsync, vsync and rgb pass through two flop stages, all aligned.
- Falling-edge detect runs on the second stage.

**hcnt** (10-bit)
- Cleared to 0 on each hsync falling edge.
- Otherwise increments, saturating at 1023.
- On each hsync fall, the line period (hcnt+1) is captured to h_total.

**vcnt** (10-bit)
- Cleared to 0 on each vsync falling edge.
- Incremented on each hsync falling edge, saturating at 1023.
- If the hsync and vsync falls coincide, vsync wins: vcnt=0 and there is no increment.

**Display-enable and coordinates**
- de = (H_START ≤ hcnt < H_START+H_ACTIVE) and (V_START ≤ vcnt < V_START+V_ACTIVE) and state≠SEARCH.
- pix_x = hcnt−H_START and pix_y = vcnt−V_START when de; otherwise both are 0.

**Checksum**
- A running sum accumulates rgb (zero-extended) on each de cycle, mod 2^16.
- On each vsync fall in TRACK or LOCKED: frame_sum ← running sum, running sum ← 0, v_total ← vcnt, frame_done=1.

**Line consistency**
- line_bad is set if any line period differs from the previous line period within the frame.

**Lock FSM**
- SEARCH: reset state.
  - On vsync fall → TRACK, good=0.
  - No frame_done on this edge.
  - The running sum is cleared.
- TRACK: on vsync fall, frame_ok = !line_bad and (good==0 or vcnt==v_ref).
  - frame_ok: v_ref←vcnt, good←good+1.
  - Otherwise: v_ref←vcnt, good←1 if !line_bad, else 0.
  - When good reaches LOCK_FRAMES → LOCKED.
  - line_bad is cleared on every vsync fall.
- LOCKED: on vsync fall, a frame that is not frame_ok → TRACK with good←0.
- Any state: hcnt or vcnt reaching 1023 (missing sync) → SEARCH, with good, line_bad and the running sum cleared.

**Output flag**
- locked = (state==LOCKED), registered.

## Timing
- Output reset values: pix_x=0, pix_y=0, de=0, h_total=0, v_total=0, locked=0, frame_sum=0, frame_done=0. The FSM resets to SEARCH.
- Latency: de, pix_x and pix_y are registered. The pin-to-output latency is 3 clocks relative to the matching rgb sample.
- frame_done, frame_sum, v_total and FSM transitions take effect 3 clocks after the vsync pin falls.
- h_total updates 3 clocks after the hsync pin falls.
- Under 640x480 source timing (800-clock line, 525 lines, first vsync fall at a frame boundary after reset):
  - TRACK on the 1st vsync fall;
  - good=1 on the 2nd;
  - locked=1 on the 3rd.
- Reset mid-frame: all state clears immediately and asynchronously. Capture restarts in SEARCH.
- Sync pulses of any width are accepted. Only falling edges matter.

## Test plan
- 640x480 generator, rgb=0 → h_total=800; v_total=525; frame_sum=0x0000; locked rises 3 clocks after the 3rd vsync fall.
- Solid rgb=6'h3F, locked → frame_sum=0x5000 (307200×63 mod 2^16); de asserted 307200 cycles per frame; pix_x spans 0..639; pix_y spans 0..479.
- One line lengthened to 801 clocks in a locked frame → locked drops at that frame's vsync fall; relock after 2 further good frames.
- hsync held high for 1100 clocks → state SEARCH; locked=0; de=0. Resuming timing relocks on the 3rd subsequent vsync fall.
- Single pixel rgb=6'h01 at x=5, y=7 → frame_sum=0x0001; de and pix_x=5, pix_y=7 appear 3 clocks after the pin sample.
- rst_n pulsed low mid-frame while locked → all outputs 0 within the reset; no frame_done on the next vsync fall; relock on the 3rd vsync fall after reset.
